// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store memory stage.
//   lsu_state_e       : FSM state encoding (IDLE, REQ, WAIT, DONE)
//   F3_*              : Funct3 access size/sign codes
//   SZ_*              : decoded access size
//   TIMEOUT_CYCLES_DEFAULT : default bus-wait abort limit
//   access_size()     : Funct3 -> access size; unknown codes decode as word
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    function automatic logic [1:0] access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane steering for the memory stage.
//   funct3      in  : access size/sign code
//   offset      in  : byte offset within the word (already size-aligned)
//   store_data  in  : right-justified store data
//   load_word   in  : raw 32-bit word returned by the bus
//   byte_en     out : byte enables for the store
//   store_lanes out : store data replicated across all lanes
//   load_data   out : selected lane, sign/zero extended
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte [4];
    logic [31:0] byte_rep;
    logic [31:0] half_rep;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        sign_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign rd_byte[gi]          = load_word[8*gi +: 8];
            assign byte_rep[8*gi +: 8]  = store_data[7:0];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_rep[16*gi +: 16] = store_data[15:0];
        end
    endgenerate

    // Funct3 bit 2 marks the unsigned load variants.
    assign sign_ext = ~funct3[2];
    assign sel_byte = rd_byte[offset];
    assign sel_half = offset[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        byte_en     = 4'b1111;
        store_lanes = store_data;
        load_data   = load_word;
        case (access_size(funct3))
            SZ_BYTE: begin
                byte_en     = 4'b0001 << offset;
                store_lanes = byte_rep;
                load_data   = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                byte_en     = 4'b0011 << {offset[1], 1'b0};
                store_lanes = half_rep;
                load_data   = {{16{sign_ext & sel_half[15]}}, sel_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage -- MEM-stage load/store unit driving a req/gnt/rvalid bus.
//   clk, reset (async, active-high)
//   MemReadM/MemWriteM/Funct3M/ALUResultM/WriteDataM : access from EX/MEM
//   StallM      : holds upstream stages while an access is outstanding
//   ReadDataM   : registered, extended load result; LoadValidM pulses with it
//   dmem_*      : data bus (req/we/addr/wdata/be out, gnt/rvalid/rdata in)
//   MisalignM, TimeoutM : one-cycle error pulses
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of issuing them with the low address bits cleared.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        LoadValidM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        MisalignM,
    output logic        TimeoutM
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REQ  = ST_REQ;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   addr_reg, wdata_reg, read_data_reg;
    logic [2:0]    f3_reg;
    logic          we_reg, load_valid_reg, timeout_reg;
    logic          access_req, trap_now, cnt_expired;
    logic [31:0]   eff_addr, wdata_calc, load_calc;
    logic [3:0]    be_calc;

    assign access_req = MemReadM | MemWriteM;
    // ">=" rather than "==": a grant on the last count moves into WAIT with
    // the counter one past the limit, which must still expire.
    assign cnt_expired = (cnt_reg >= CNT_LAST);

    // Size-aligned address; low bits that violate alignment are dropped.
    always_comb begin
        eff_addr = ALUResultM;
        case (access_size(Funct3M))
            SZ_HALF: eff_addr[0]   = 1'b0;
            SZ_WORD: eff_addr[1:0] = 2'b00;
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_reg;
    // Misaligned exactly when alignment had to clear a set address bit.
    assign trap_now = access_req && (eff_addr[1:0] != ALUResultM[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_reg <= 1'b0;
        else       misalign_reg <= (state_reg == IDLE) && trap_now;
    end
    assign MisalignM = misalign_reg;
`else
    assign trap_now  = 1'b0;
    assign MisalignM = 1'b0;
`endif

    // Lane steering works from the latched access so bus fields stay stable.
    lsu_align u_align (
        .funct3      (f3_reg),
        .offset      (addr_reg[1:0]),
        .store_data  (wdata_reg),
        .load_word   (dmem_rdata),
        .byte_en     (be_calc),
        .store_lanes (wdata_calc),
        .load_data   (load_calc)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: if (access_req) begin
                state_next = trap_now ? DONE : REQ;
                cnt_next   = '0;
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_next = we_reg ? DONE : WAIT;
                    cnt_next   = cnt_reg + CW'(1);
                end else if (cnt_expired) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT: begin
                if (dmem_rvalid || cnt_expired) state_next = DONE;
                else                            cnt_next   = cnt_reg + CW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            f3_reg         <= '0;
            we_reg         <= 1'b0;
            read_data_reg  <= '0;
            load_valid_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            load_valid_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            case (state_reg)
                IDLE: if (access_req) begin
                    addr_reg  <= eff_addr;
                    wdata_reg <= WriteDataM;
                    f3_reg    <= Funct3M;
                    // Read+write together is a store.
                    we_reg    <= MemWriteM;
                    if (trap_now) begin
                        load_valid_reg <= ~MemWriteM;
                        read_data_reg  <= '0;
                    end
                end
                REQ: if (!dmem_gnt && cnt_expired) begin
                    timeout_reg    <= 1'b1;
                    load_valid_reg <= ~we_reg;
                    read_data_reg  <= '0;
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        read_data_reg  <= load_calc;
                        load_valid_reg <= 1'b1;
                    end else if (cnt_expired) begin
                        timeout_reg    <= 1'b1;
                        load_valid_reg <= 1'b1;
                        read_data_reg  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stall is forced low during reset so every output reads 0 at once.
    assign StallM = ~reset & (((state_reg == IDLE) & access_req) |
                              (state_reg == REQ) | (state_reg == WAIT));

    assign dmem_req   = (state_reg == REQ);
    assign dmem_we    = dmem_req & we_reg;
    assign dmem_be    = dmem_req ? be_calc : 4'b0000;
    assign dmem_addr  = {addr_reg[31:2], 2'b00};
    assign dmem_wdata = wdata_calc;
    assign ReadDataM  = read_data_reg;
    assign LoadValidM = load_valid_reg;
    assign TimeoutM   = timeout_reg;

endmodule
